// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter with bounded hold time, placed in front of the
// shared BUS master port. Grants are registered; the BUS-side mux is combinational.
module bus_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 64,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m1_req,
    input  logic              m0_wr,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m0_dout,
    input  logic [DATA_W-1:0] m1_dout,
    output logic              m0_grant,
    output logic              m1_grant,
    output logic [DATA_W-1:0] m0_din,
    output logic [DATA_W-1:0] m1_din,
    output logic              b_req,
    output logic              b_wr,
    output logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] b_dout,
    input  logic [DATA_W-1:0] b_din
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    localparam bit         HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LAST = HOLD_EN ? 8'(MAX_HOLD - 1) : 8'd0;

    state_t      state_r;
    state_t      next_state_s;
    logic        last_r;
    logic [7:0]  hold_cnt_r;
    logic        m0_grant_r;
    logic        m1_grant_r;
    logic        hold_expired_s;

    // The equality (not >=) means a late request from the waiting master does
    // not preempt a holder that has already run past the limit alone.
    assign hold_expired_s = HOLD_EN && (hold_cnt_r == HOLD_LAST);

    // Next-state arbitration: round-robin on ties, handoff and preemption from grant states.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (m0_req && m1_req) begin
                    next_state_s = last_r ? ST_GNT0 : ST_GNT1;
                end else if (m0_req) begin
                    next_state_s = ST_GNT0;
                end else if (m1_req) begin
                    next_state_s = ST_GNT1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_GNT0: begin
                if (!m0_req) begin
                    next_state_s = m1_req ? ST_GNT1 : ST_IDLE;
                end else if (m1_req && hold_expired_s) begin
                    next_state_s = ST_GNT1;
                end else begin
                    next_state_s = ST_GNT0;
                end
            end
            ST_GNT1: begin
                if (!m1_req) begin
                    next_state_s = m0_req ? ST_GNT0 : ST_IDLE;
                end else if (m0_req && hold_expired_s) begin
                    next_state_s = ST_GNT0;
                end else begin
                    next_state_s = ST_GNT1;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State, round-robin pointer, hold counter and registered grants.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            last_r     <= 1'b1;
            hold_cnt_r <= 8'd0;
            m0_grant_r <= 1'b0;
            m1_grant_r <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            m0_grant_r <= (next_state_s == ST_GNT0);
            m1_grant_r <= (next_state_s == ST_GNT1);
            if (next_state_s != state_r) begin
                hold_cnt_r <= 8'd0;
                if (next_state_s == ST_GNT0) begin
                    last_r <= 1'b0;
                end else if (next_state_s == ST_GNT1) begin
                    last_r <= 1'b1;
                end else begin
                    last_r <= last_r;
                end
            end else if (state_r == ST_IDLE) begin
                hold_cnt_r <= 8'd0;
            end else if (hold_cnt_r != 8'hff) begin
                hold_cnt_r <= hold_cnt_r + 8'd1;
            end else begin
                hold_cnt_r <= hold_cnt_r;
            end
        end
    end

    // BUS-side mux: the granted master's signals pass straight through.
    always_comb begin
        b_req  = 1'b0;
        b_wr   = 1'b0;
        b_addr = '0;
        b_dout = '0;
        if (m0_grant_r) begin
            b_req  = m0_req;
            b_wr   = m0_wr;
            b_addr = m0_addr;
            b_dout = m0_dout;
        end else if (m1_grant_r) begin
            b_req  = m1_req;
            b_wr   = m1_wr;
            b_addr = m1_addr;
            b_dout = m1_dout;
        end else begin
            b_req  = 1'b0;
            b_wr   = 1'b0;
            b_addr = '0;
            b_dout = '0;
        end
    end

    assign m0_grant = m0_grant_r;
    assign m1_grant = m1_grant_r;
    assign m0_din   = b_din;
    assign m1_din   = b_din;

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter placed in front of the shared `BUS` block's master port. It lets two requesters (for example a CPU-side master and a DMA-style master) share the single BUS master interface. Arbitration is round-robin, with a bounded hold time. The block decodes the grant from a small FSM and drives the granted master's request, write, address and data onto the BUS master port. BUS read data is returned to both masters.

## Interface
- `ADDR_W`, 16, address width (matches BUS `m_addr`)
- `DATA_W`, 64, data width (matches BUS `m_dout`/`m_din`)
- `MAX_HOLD`, 8, maximum consecutive grant cycles while the other master waits; range 1..255; 0 disables preemption

Ports. One clock; reset is asynchronous and active-high.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `m0_req`, `m1_req`  in  1  bus request from master 0 / 1
- `m0_wr`, `m1_wr`  in  1  1 = write, 0 = read
- `m0_addr`, `m1_addr`  in  ADDR_W  transfer address
- `m0_dout`, `m1_dout`  in  DATA_W  write data
- `m0_grant`, `m1_grant`  out  1  registered grant; at most one is high
- `m0_din`, `m1_din`  out  DATA_W  read data; both equal `b_din`
- `b_req`  out  1  to BUS `m_req`
- `b_wr`  out  1  to BUS `m_wr`
- `b_addr`  out  ADDR_W  to BUS `m_addr`
- `b_dout`  out  DATA_W  to BUS `m_dout`
- `b_din`  in  DATA_W  from BUS `m_din`

## Operation
FSM states and what each drives:
- IDLE: `b_req`, `b_wr`, `b_addr`, `b_dout` = 0.
- GNT0: `m0_grant` = 1; `b_*` = the `m0_*` inputs, combinational pass-through.
- GNT1: `m1_grant` = 1; `b_*` = the `m1_*` inputs, combinational pass-through.

Round-robin pointer `last`:
- 1-bit register holding the index of the most recently granted master.
- Updated on every entry into GNT0 or GNT1.

Transitions from IDLE:
- Only `m0_req` high → GNT0.
- Only `m1_req` high → GNT1.
- Both high → grant the master ≠ `last`.
- Neither high → stay in IDLE.

Transitions from GNTx (o = the other master):
- `mx_req` low, `mo_req` high → GNTo directly, with no idle cycle.
- `mx_req` low, `mo_req` low → IDLE.
- `mx_req` high, `mo_req` high, MAX_HOLD ≠ 0, `hold_cnt` = MAX_HOLD−1 → GNTo (preemption).
- Otherwise → stay in GNTx.

`hold_cnt`:
- 8-bit counter, cleared on every state change and in IDLE.
- Increments each cycle spent in a grant state, saturating at 255.

Grants are decoded from registered state, so they are glitch-free.

## Timing
- Reset (asynchronous, takes effect immediately on assertion):
  - state = IDLE, `last` = 1 (so m0 wins the first tie), `hold_cnt` = 0.
  - `m0_grant` = `m1_grant` = 0.
  - `b_req` = `b_wr` = 0, `b_addr` = 0, `b_dout` = 0.
  - `m*_din` follow `b_din` at all times, including during reset.
- Grant latency: a request sampled at rising edge N produces a grant visible after edge N. This is one cycle from request assertion when the arbiter is IDLE.
- Handoff: master x deasserts its request at edge N and master o is requesting → `mo_grant` rises and `mx_grant` falls at the same edge. The two grants never overlap.
- A granted master dropping `req` drops `b_req` in the same cycle, because `b_req` follows the input combinationally.
- Preemption: with MAX_HOLD = k, a master granted while the other continuously requests holds the bus for exactly k cycles.
- Reset asserted mid-grant: outputs return to reset values without waiting for a clock edge. After release, arbitration restarts from IDLE with m0 favoured.

## Test plan
- Reset: hold `reset` = 1 with both requests high → both grants 0, `b_addr` = 16'h0000, `b_req` = 0. Release → `m0_grant` = 1 one cycle later.
- Single master: only `m1_req` = 1, `m1_wr` = 0, `m1_addr` = 16'h70ff → after one edge `m1_grant` = 1, `b_addr` = 16'h70ff, `b_wr` = 0. Drive `b_din` = 64'h0f0f → `m0_din` = `m1_din` = 64'h0f0f.
- Tie and round-robin: both requests asserted from IDLE after reset → GNT0. m0 drops its request → `m1_grant` rises at the same edge with no IDLE cycle. m1 drops, then both re-assert together → m0 granted.
- Preemption with MAX_HOLD = 4: both requests held high → grant alternates m0 ×4, m1 ×4, m0 ×4 cycles. With MAX_HOLD = 0 → m0 keeps the grant indefinitely.
- Mux integrity:
  - m0 writes 16'h07ff / 64'hffff while m1 waits with 16'h6060 → `b_addr` = 16'h07ff, `b_wr` = 1, `b_dout` = 64'hffff.
  - After handoff → `b_addr` = 16'h6060.
- Async reset mid-grant: assert `reset` between clock edges while in GNT1 → `m1_grant` and `b_req` go to 0 before the next edge.
